// File: rtl/vga_gradient_filter.sv
// ============================================================================
// Module      : vga_gradient_filter
// Description : Two-stage streaming VGA gradient filter (horizontal/vertical/
//               combined) with per-channel bypass, gain, freeze and line LEDs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_gradient_filter #(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480,
  parameter int DW     = 8
) (
  input  logic          VGA_CLK,
  input  logic          reset,
  input  logic [DW-1:0] iVGA_R,
  input  logic [DW-1:0] iVGA_G,
  input  logic [DW-1:0] iVGA_B,
  input  logic          iVGA_HS,
  input  logic          iVGA_VS,
  input  logic          iVGA_SYNC_N,
  input  logic          iVGA_BLANK_N,
  output logic [DW-1:0] oVGA_R,
  output logic [DW-1:0] oVGA_G,
  output logic [DW-1:0] oVGA_B,
  output logic          oVGA_HS,
  output logic          oVGA_VS,
  output logic          oVGA_SYNC_N,
  output logic          oVGA_BLANK_N,
  input  logic [7:0]    SW,
  output logic [9:0]    LEDR
);

  localparam int             XW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int             PW    = 3 * DW;
  localparam logic [XW-1:0]  X_MAX = XW'(WIDTH - 1);
  localparam logic [9:0]     Y_MAX = 10'(HEIGHT - 1);
  localparam logic [1:0]     MODE_PASS = 2'b00;
  localparam logic [1:0]     MODE_H    = 2'b01;
  localparam logic [1:0]     MODE_V    = 2'b10;

  logic [PW-1:0] pix_w;
  assign pix_w = {iVGA_R, iVGA_G, iVGA_B};

  // Stage 0: position tracking
  logic [XW-1:0] x_q, x_d;
  logic [9:0]    y_q, y_d;
  logic          line_valid_q, line_valid_d;
  logic          blank_prev_q;

  always_comb begin
    x_d          = x_q;
    y_d          = y_q;
    line_valid_d = line_valid_q;
    if (iVGA_BLANK_N) begin
      if (x_q != X_MAX) x_d = x_q + 1'b1;
    end else begin
      x_d = '0;
    end
    if (blank_prev_q && !iVGA_BLANK_N) begin
      line_valid_d = 1'b1;
      if (y_q != Y_MAX) y_d = y_q + 1'b1;
    end
    if (!iVGA_VS) begin
      y_d          = '0;
      line_valid_d = 1'b0;
    end
  end

  // Line buffer: the read returns the previous line's pixel before it is overwritten
  logic [PW-1:0] line_mem [WIDTH];
  logic [PW-1:0] mem_rd_q;

  always_ff @(posedge VGA_CLK) begin
    if (iVGA_BLANK_N && !SW[7]) line_mem[x_q] <= pix_w;
    mem_rd_q <= line_mem[x_q];
  end

  // Stage 1 registers
  logic [PW-1:0] prev_pix_q, cur_q, left_q;
  logic          lv_s1_q;
  logic [6:0]    sw_q;
  logic [3:0]    sync_q;

  always_ff @(posedge VGA_CLK or posedge reset) begin
    if (reset) begin
      x_q          <= '0;
      y_q          <= '0;
      line_valid_q <= 1'b0;
      blank_prev_q <= 1'b0;
      prev_pix_q   <= '0;
      cur_q        <= '0;
      left_q       <= '0;
      lv_s1_q      <= 1'b0;
      sw_q         <= '0;
      sync_q       <= '0;
    end else begin
      x_q          <= x_d;
      y_q          <= y_d;
      line_valid_q <= line_valid_d;
      blank_prev_q <= iVGA_BLANK_N;
      if (iVGA_BLANK_N) prev_pix_q <= pix_w;
      cur_q        <= pix_w;
      left_q       <= (x_q == '0) ? pix_w : prev_pix_q;
      lv_s1_q      <= line_valid_q;
      sw_q         <= SW[6:0];
      sync_q       <= {iVGA_HS, iVGA_VS, iVGA_SYNC_N, iVGA_BLANK_N};
    end
  end

  // Stage 2: per-channel gradient; channel 0 is B (enable SW[4]), channel 2 is R (SW[2])
  logic [1:0]    mode_w;
  logic [1:0]    gain_w;
  logic [PW-1:0] col_d;
  assign mode_w = sw_q[1:0];
  assign gain_w = sw_q[6:5];

  for (genvar c = 0; c < 3; c++) begin : g_ch
    logic [DW-1:0] cur_w, left_w, up_w, res_w, sat_w;
    logic [DW:0]   dh_w, dv_w;
    logic [DW+1:0] grad_w;
    logic [DW+4:0] shl_w;
    logic          en_w;

    assign cur_w  = cur_q[c*DW +: DW];
    assign left_w = left_q[c*DW +: DW];
    assign up_w   = lv_s1_q ? mem_rd_q[c*DW +: DW] : cur_w;
    assign en_w   = sw_q[4-c];
    assign dh_w   = (cur_w >= left_w) ? ({1'b0, cur_w} - {1'b0, left_w})
                                      : ({1'b0, left_w} - {1'b0, cur_w});
    assign dv_w   = (cur_w >= up_w) ? ({1'b0, cur_w} - {1'b0, up_w})
                                    : ({1'b0, up_w} - {1'b0, cur_w});
    assign grad_w = (mode_w == MODE_H) ? {1'b0, dh_w} :
                    (mode_w == MODE_V) ? {1'b0, dv_w} :
                                         ({1'b0, dh_w} + {1'b0, dv_w});
    assign shl_w  = {3'b000, grad_w} << gain_w;
    assign sat_w  = (|shl_w[DW+4:DW]) ? {DW{1'b1}} : shl_w[DW-1:0];
    assign res_w  = (!en_w || mode_w == MODE_PASS) ? cur_w : sat_w;
    assign col_d[c*DW +: DW] = sync_q[0] ? res_w : '0;
  end

  logic [PW-1:0] out_q;
  logic [3:0]    osync_q;

  always_ff @(posedge VGA_CLK or posedge reset) begin
    if (reset) begin
      out_q   <= '0;
      osync_q <= '0;
    end else begin
      out_q   <= col_d;
      osync_q <= sync_q;
    end
  end

  assign {oVGA_R, oVGA_G, oVGA_B} = out_q;
  assign {oVGA_HS, oVGA_VS, oVGA_SYNC_N, oVGA_BLANK_N} = osync_q;
  assign LEDR = y_q;

endmodule

`default_nettype wire

// File: tb/tb_vga_gradient_filter.sv
// ============================================================================
// Module      : tb_vga_gradient_filter
// Description : Directed bench for vga_gradient_filter on 10x10 frames.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vga_gradient_filter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] iR = '0, iG = '0, iB = '0;
  logic       iHS = 1'b1, iVS = 1'b1, iSYNC = 1'b0, iBLANK = 1'b0;
  logic [7:0] sw = '0;
  logic [7:0] oR, oG, oB;
  logic       oHS, oVS, oSYNC, oBLANK;
  logic [9:0] ledr;

  int checks = 0;
  int errors = 0;
  logic [27:0] obs, prev_exp, cur_exp;

  always #5 clk = ~clk;

  vga_gradient_filter #(.WIDTH(640), .HEIGHT(480), .DW(8)) dut (
    .VGA_CLK(clk), .reset(rst),
    .iVGA_R(iR), .iVGA_G(iG), .iVGA_B(iB),
    .iVGA_HS(iHS), .iVGA_VS(iVS), .iVGA_SYNC_N(iSYNC), .iVGA_BLANK_N(iBLANK),
    .oVGA_R(oR), .oVGA_G(oG), .oVGA_B(oB),
    .oVGA_HS(oHS), .oVGA_VS(oVS), .oVGA_SYNC_N(oSYNC), .oVGA_BLANK_N(oBLANK),
    .SW(sw), .LEDR(ledr)
  );

  assign obs = {oR, oG, oB, oHS, oVS, oSYNC, oBLANK};

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Input pattern and hand-derived expected colours for each test
  task automatic pat(input int t, input int x, input int y,
                     output logic [7:0] r, output logic [7:0] g, output logic [7:0] b,
                     output logic [7:0] er, output logic [7:0] eg, output logic [7:0] eb);
    r = 8'(x); g = 8'(y); b = 8'(x + y); er = 0; eg = 0; eb = 0;
    case (t)
      1: begin er = r; eg = g; eb = b; end
      2: begin r = 8'(3*x); er = (x == 0) ? 8'd0 : 8'd3; eb = (x == 0) ? 8'd0 : 8'd1; end
      3: begin g = 8'(5*y); eg = (y == 0) ? 8'd0 : 8'd5; eb = (y == 0) ? 8'd0 : 8'd1; end
      4: begin r = (x >= 5) ? 8'd40 : 8'd0; g = 0; b = 0; er = (x == 5) ? 8'd255 : 8'd0; end
      5: begin r = 8'(3*x); b = 8'(3*x); er = r; eg = g; eb = (x == 0) ? 8'd0 : 8'd3; end
      7: begin
        g = 8'(5*y);
        if (y != 0) begin
          er = 8'(2*x); eg = 8'(iabs(5*y - 9)); eb = 8'(iabs(y - 2*x));
        end
      end
      default: ;
    endcase
  endtask

  task automatic step(input string tag, input logic [7:0] r, input logic [7:0] g,
                      input logic [7:0] b, input logic hs, input logic vs, input logic bl,
                      input logic [7:0] er, input logic [7:0] eg, input logic [7:0] eb);
    iR = r; iG = g; iB = b; iHS = hs; iVS = vs; iBLANK = bl;
    cur_exp = {er, eg, eb, hs, vs, 1'b0, bl};
    @(posedge clk); #1;
    chk(tag, obs, prev_exp);
    prev_exp = cur_exp;
  endtask

  task automatic line(input string tag, input int t, input int yl);
    logic [7:0] r, g, b, er, eg, eb;
    for (int x = 0; x < 10; x++) begin
      pat(t, x, yl, r, g, b, er, eg, eb);
      step(tag, r, g, b, 1'b1, 1'b1, 1'b1, er, eg, eb);
    end
    chk("ledr_line", 32'(ledr), 32'(yl));
    for (int k = 0; k < 4; k++) begin
      step("hblank", 0, 0, 0, !(k == 1 || k == 2), 1'b1, 1'b0, 0, 0, 0);
      if (k == 0) chk("ledr_inc", 32'(ledr), 32'(yl + 1));
    end
  endtask

  task automatic vblank();
    for (int k = 0; k < 6; k++)
      step("vblank", 0, 0, 0, 1'b1, !(k >= 1 && k <= 3), 1'b0, 0, 0, 0);
    chk("ledr_vs", 32'(ledr), 0);
  endtask

  task automatic frame(input string tag, input logic [7:0] s, input int t);
    sw = s;
    for (int y = 0; y < 10; y++) line(tag, t, y);
    vblank();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out", 32'(obs), 0);
    chk("reset_ledr", 32'(ledr), 0);
    rst = 1'b0;
    prev_exp = '0;

    frame("pass", 8'h00, 1);
    frame("dh", 8'h1D, 2);
    frame("dv", 8'h1E, 3);
    frame("dv_f2", 8'h1E, 3);
    frame("sat", 8'h7F, 4);
    frame("en_b", 8'h11, 5);
    frame("freeze", 8'h9E, 7);

    // Reset asserted mid-line, then restart from line 0
    sw = 8'h1E;
    line("rst_pre", 3, 0);
    line("rst_pre", 3, 1);
    for (int x = 0; x < 4; x++)
      step("rst_mid", 8'(x), 8'd10, 8'(x + 2), 1'b1, 1'b1, 1'b1, 0, 8'd5, 8'd1);
    rst = 1'b1;
    iR = 0; iG = 0; iB = 0; iBLANK = 1'b0;
    #1;
    chk("rst_async", 32'(obs), 0);
    chk("rst_ledr", 32'(ledr), 0);
    repeat (3) begin
      @(posedge clk); #1;
      chk("rst_hold", 32'(obs), 0);
    end
    rst = 1'b0;
    prev_exp = '0;
    for (int k = 0; k < 3; k++) step("rst_rel", 0, 0, 0, 1'b1, 1'b1, 1'b0, 0, 0, 0);
    line("rst_l0", 3, 0);
    line("rst_l1", 3, 1);
    vblank();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
